// File: rtl/manhattan_wta_engine.sv
// manhattan_wta_engine
//   Block-matching distance engine. Accumulates |X - T_c| for NUM_CH template
//   channels over BLOCK_LEN pixels (sum for Manhattan, max for Chebyshev),
//   then walks the channels one per clock to find the closest template.
//
// State table:
//   S_ACCUM | accepting pixels, InReady=1
//   S_CMP   | winner-take-all scan, one channel per clock (cidx)
//   S_LOAD  | copy accumulators and winner into the output registers
//   S_OUT   | OutValid=1, waiting for OutReady
//
// Ports:
//   Clk, Rst       clock (rising edge), synchronous active-high reset
//   Mode           0 = Manhattan, 1 = Chebyshev; latched on first pixel of a block
//   InValid/InReady  pixel handshake for X and T
//   X              input pixel, DATA_W bits unsigned
//   T              template pixels, channel c at [c*DATA_W +: DATA_W]
//   OutValid/OutReady  result handshake
//   Dist           per-channel distances, channel c at [c*ACC_W +: ACC_W]
//   WinIdx         index of the minimum-distance channel (lowest index on ties)
//   WinDist        minimum distance
module manhattan_wta_engine #(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 16,
  parameter int NUM_CH    = 4,
  parameter int ACC_W     = DATA_W + $clog2(BLOCK_LEN),
  parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Mode,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_W-1:0]        X,
  input  logic [NUM_CH*DATA_W-1:0] T,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [NUM_CH*ACC_W-1:0]  Dist,
  output logic [IDX_W-1:0]         WinIdx,
  output logic [ACC_W-1:0]         WinDist
);

  localparam int CNT_W = $clog2(BLOCK_LEN);

  typedef enum logic [1:0] {S_ACCUM, S_CMP, S_LOAD, S_OUT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   cidx;
  logic               mode_q;
  logic [ACC_W-1:0]   acc [NUM_CH];
  logic [ACC_W-1:0]   min_dist;
  logic [IDX_W-1:0]   min_idx;

  logic               first_pix;
  logic               eff_mode;
  logic [DATA_W:0]    diff_pos [NUM_CH];
  logic [DATA_W:0]    diff_neg [NUM_CH];
  logic [ACC_W-1:0]   absd     [NUM_CH];
  logic [ACC_W-1:0]   acc_nxt  [NUM_CH];

  // Differences are taken one bit wider than the pixels so the sign bit
  // picks the non-negative ordering; |0-255| = 255 without wrap.
  always_comb begin
    first_pix = (count == '0);
    eff_mode  = first_pix ? Mode : mode_q;
    for (int c = 0; c < NUM_CH; c++) begin
      diff_pos[c] = {1'b0, X} - {1'b0, T[c*DATA_W +: DATA_W]};
      diff_neg[c] = {1'b0, T[c*DATA_W +: DATA_W]} - {1'b0, X};
      absd[c]     = diff_pos[c][DATA_W] ? ACC_W'(diff_neg[c]) : ACC_W'(diff_pos[c]);
      if (first_pix)
        acc_nxt[c] = absd[c];
      else if (eff_mode)
        acc_nxt[c] = (absd[c] > acc[c]) ? absd[c] : acc[c];
      else
        acc_nxt[c] = acc[c] + absd[c];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_ACCUM;
      count    <= '0;
      cidx     <= '0;
      mode_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      min_dist <= '0;
      min_idx  <= '0;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Dist     <= '0;
      WinIdx   <= '0;
      WinDist  <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (InValid) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
            if (first_pix) mode_q <= Mode;
            if (count == CNT_W'(BLOCK_LEN - 1)) begin
              count   <= '0;
              cidx    <= '0;
              InReady <= 1'b0;
              state   <= S_CMP;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        S_CMP: begin
          // Channel 0 seeds the running minimum; strict less-than keeps
          // the lowest index on ties.
          if (cidx == '0 || acc[cidx] < min_dist) begin
            min_dist <= acc[cidx];
            min_idx  <= cidx;
          end
          if (cidx == IDX_W'(NUM_CH - 1))
            state <= S_LOAD;
          else
            cidx <= cidx + IDX_W'(1);
        end
        S_LOAD: begin
          for (int c = 0; c < NUM_CH; c++) Dist[c*ACC_W +: ACC_W] <= acc[c];
          WinIdx   <= min_idx;
          WinDist  <= min_dist;
          OutValid <= 1'b1;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            state    <= S_ACCUM;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_manhattan_wta_engine.sv
// tb_manhattan_wta_engine
//   Self-checking bench for manhattan_wta_engine at DATA_W=8, BLOCK_LEN=16,
//   NUM_CH=4. Block vectors come from a table; expected results are queued
//   when a block is driven and compared when the engine presents a result.
module tb_manhattan_wta_engine;

  localparam int DATA_W = 8;
  localparam int BLOCK_LEN = 16;
  localparam int NUM_CH = 4;
  localparam int ACC_W = 12;
  localparam int IDX_W = 2;

  logic                     Clk;
  logic                     Rst;
  logic                     Mode;
  logic                     InValid;
  logic                     InReady;
  logic [DATA_W-1:0]        X;
  logic [NUM_CH*DATA_W-1:0] T;
  logic                     OutValid;
  logic                     OutReady;
  logic [NUM_CH*ACC_W-1:0]  Dist;
  logic [IDX_W-1:0]         WinIdx;
  logic [ACC_W-1:0]         WinDist;

  manhattan_wta_engine #(
    .DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN), .NUM_CH(NUM_CH)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .InValid(InValid), .InReady(InReady),
    .X(X), .T(T), .OutValid(OutValid), .OutReady(OutReady),
    .Dist(Dist), .WinIdx(WinIdx), .WinDist(WinDist)
  );

  typedef struct packed {
    logic                   mode;
    logic                   ramp;   // X = pixel index instead of xb
    logic [7:0]             xb;
    logic [3:0][7:0]        t;
    logic                   tog;    // flip Mode from pixel 7 onward
    logic [3:0][11:0]       ed;
    logic [1:0]             ei;
    logic [11:0]            ew;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];
  vec_t sb [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic ov_prev = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic m, input logic r, input int xb,
                              input int t0, input int t1, input int t2, input int t3,
                              input logic tg,
                              input int d0, input int d1, input int d2, input int d3,
                              input int ei, input int ew);
    vec_t v;
    v.mode = m; v.ramp = r; v.xb = 8'(xb);
    v.t[0] = 8'(t0); v.t[1] = 8'(t1); v.t[2] = 8'(t2); v.t[3] = 8'(t3);
    v.tog = tg;
    v.ed[0] = 12'(d0); v.ed[1] = 12'(d1); v.ed[2] = 12'(d2); v.ed[3] = 12'(d3);
    v.ei = 2'(ei); v.ew = 12'(ew);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic drive_block(input vec_t v, input bit gaps, input int npix);
    int w;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        @(negedge Clk);
        InValid = 1'b0;
        X = 8'($urandom);
      end
      @(negedge Clk);
      InValid = 1'b1;
      Mode = (v.tog && i >= 7) ? ~v.mode : v.mode;
      X = v.ramp ? 8'(i) : v.xb;
      T = v.t;
      w = 0;
      while (!InReady && w < 200) begin
        @(negedge Clk);
        w++;
      end
      if (w >= 200) bound_fail("inready_wait");
      @(posedge Clk);
      #1;
      last_acc_cyc = cyc;
    end
    InValid = 1'b0;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 500) bound_fail("result_wait");
    @(negedge Clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inready"}, InReady, 1);
    chk({tag, "_outvalid"}, OutValid, 0);
    chk({tag, "_dist"}, Dist, 0);
    chk({tag, "_winidx"}, WinIdx, 0);
    chk({tag, "_windist"}, WinDist, 0);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Rst = 1'b1;
    InValid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    vec_t e;
    int w;

    //        mode ramp xb   T0   T1   T2   T3  tog  D0    D1  D2    D3    idx wd
    vt[0] = mk(0, 0, 100,  90, 100, 120,   0, 0,  160,   0, 320, 1600, 1,   0);
    vt[1] = mk(0, 0,   0, 255,   0,   0,   0, 0, 4080,   0,   0,    0, 1,   0);
    vt[2] = mk(0, 0,  10,  13,  20,   7,   0, 0,   48, 160,  48,  160, 0,  48);
    vt[3] = mk(1, 1,   0,   5,  15,   0,   8, 1,   10,  15,  15,    8, 3,   8);
    vt[4] = mk(1, 0,   0, 255, 255, 255, 254, 0,  255, 255, 255,  254, 3, 254);
    vt[5] = mk(0, 0, 255,   0, 250, 128, 254, 0, 4080,  80, 2032,  16, 3,  16);

    Rst = 1'b1; Mode = 1'b0; InValid = 1'b0; X = '0; T = '0; OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs("reset");
    Rst = 1'b0;

    fork
      forever begin
        @(negedge Clk);
        if (Rst) begin
          ov_prev = 1'b0;
        end else begin
          if (OutValid && !ov_prev) chk("latency", cyc - last_acc_cyc, 5);
          ov_prev = OutValid;
          if (OutValid && OutReady) begin
            if (sb.size() == 0) begin
              bound_fail("unexpected_outvalid");
            end else begin
              e = sb.pop_front();
              for (int c = 0; c < NUM_CH; c++)
                chk($sformatf("dist%0d", c), Dist[c*ACC_W +: ACC_W], e.ed[c]);
              chk("winidx", WinIdx, e.ei);
              chk("windist", WinDist, e.ew);
            end
            @(negedge Clk);
            chk("inready_after_hs", InReady, 1);
            chk("outvalid_after_hs", OutValid, 0);
            ov_prev = OutValid;
          end
        end
      end
    join_none

    // Back-to-back table blocks.
    for (int k = 0; k < NV; k++) begin
      sb.push_back(vt[k]);
      drive_block(vt[k], 1'b0, BLOCK_LEN);
    end
    wait_empty();

    // InValid gaps every other cycle give the gapless result.
    sb.push_back(vt[0]);
    drive_block(vt[0], 1'b1, BLOCK_LEN);
    wait_empty();

    // Backpressure: result held, input side closed and ignored.
    @(posedge Clk); #1;
    OutReady = 1'b0;
    sb.push_back(vt[3]);
    drive_block(vt[3], 1'b0, BLOCK_LEN);
    w = 0;
    while (!OutValid && w < 50) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 50) bound_fail("outvalid_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      X = 8'($urandom);
      T = {$urandom, $urandom};
      InValid = 1'b1;
      Mode = ~Mode;
      chk("bp_outvalid", OutValid, 1);
      chk("bp_inready", InReady, 0);
      chk("bp_dist", Dist, vt[3].ed);
      chk("bp_winidx", WinIdx, vt[3].ei);
    end
    @(posedge Clk); #1;
    InValid = 1'b0;
    OutReady = 1'b1;
    sb.push_back(vt[1]);
    drive_block(vt[1], 1'b0, BLOCK_LEN);
    wait_empty();

    // Reset after 7 accepted pixels.
    drive_block(vt[1], 1'b0, 7);
    pulse_reset();
    chk_reset_outputs("rst_mid_block");

    // Reset while comparing.
    drive_block(vt[2], 1'b0, BLOCK_LEN);
    @(negedge Clk);
    chk("in_cmp_inready", InReady, 0);
    pulse_reset();
    chk_reset_outputs("rst_in_cmp");
    repeat (12) @(negedge Clk);
    chk("no_outvalid_after_rst", OutValid, 0);

    // Clean block after the resets.
    sb.push_back(vt[0]);
    drive_block(vt[0], 1'b0, BLOCK_LEN);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/manhattan_wta_engine.md
Name: manhattan_wta_engine

Overview:
- Block-matching distance engine: accumulates per-pixel absolute differences between an input pixel stream X and NUM_CH parallel template streams over BLOCK_LEN pixels.
- Then runs a sequential winner-take-all search for the closest template.
- Successor to the single-channel fixed-16 Manhattan accumulator: parametrised width, length and channel count; adds L1/L-infinity mode, valid/ready handshakes and a min-index output.
- Sits between the pixel fetch stage and the match decision logic.

Parameters:
- DATA_W, 8: pixel width, unsigned.
- BLOCK_LEN, 16: pixels per block, >=2.
- NUM_CH, 4: template channels, >=1.
- ACC_W, DATA_W+$clog2(BLOCK_LEN): accumulator and distance width.
- IDX_W, max(1,$clog2(NUM_CH)): winner index width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Mode  in  1  0 = Manhattan (sum of abs diff), 1 = Chebyshev (max abs diff); sampled on the first accepted pixel of each block.
- InValid  in  1  X/T valid.
- InReady  out  1  block accepts a pixel.
- X  in  DATA_W  input pixel.
- T  in  NUM_CH*DATA_W  template pixels; channel c at [c*DATA_W +: DATA_W].
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- Dist  out  NUM_CH*ACC_W  per-channel distances; channel c at [c*ACC_W +: ACC_W].
- WinIdx  out  IDX_W  index of the minimum-distance channel.
- WinDist  out  ACC_W  minimum distance.

Behaviour:
- Reset (Rst high at a rising edge) forces:
  - state ACCUM, pixel count 0, accumulators 0.
  - InReady=1, OutValid=0, Dist=0, WinIdx=0, WinDist=0.
  - Reset mid-block or mid-compare discards all partial results; no OutValid follows.
- States and transitions:
  - ACCUM: InReady=1. A pixel is accepted when InValid&&InReady.
    - Per channel: d=|X-T_c|, computed unsigned in DATA_W+1 bits; no wrap, so |0-255| = 255.
    - Mode 0: acc_c += d.
    - Mode 1: acc_c = max(acc_c, d), zero-extended.
    - The first pixel of a block overwrites acc_c instead of combining, and latches Mode.
    - The count increments on each accept. InValid low stalls with no state change.
    - The accept with count==BLOCK_LEN-1 goes to CMP with cidx=0 and count reset.
  - CMP: InReady=0. Compares one channel per clock, cidx=0..NUM_CH-1.
    - Running min starts at channel 0.
    - Replacement uses strict less-than only, so ties keep the lowest index.
    - After the cycle with cidx=NUM_CH-1, goes to OUT.
  - OUT: OutValid=1, InReady=0.
    - Dist, WinIdx and WinDist are registered and stable while OutValid is high.
    - On OutValid&&OutReady, goes to ACCUM; InReady=1 the next cycle.
    - Dist and WinIdx/WinDist hold their last values after the handshake until the next OUT.
- Latency: OutValid rises NUM_CH+1 rising edges after the edge accepting the last pixel.
- Throughput: at most one block per BLOCK_LEN+NUM_CH+1 cycles. Backpressure extends OUT indefinitely.
- Width: ACC_W holds BLOCK_LEN*(2^DATA_W-1) exactly (16*255=4080 fits 12 bits). No saturation logic is required.
- X/T/InValid are ignored outside ACCUM.
- Mode changes mid-block have no effect until the next block's first pixel.

Test Plan (DATA_W=8, BLOCK_LEN=16, NUM_CH=4):
1. Mode 0; X=100 for 16 pixels; T0=90, T1=100, T2=120, T3=0 -> Dist={160,0,320,1600}, WinIdx=1, WinDist=0. OutValid rises 5 edges after the 16th accept.
2. Mode 0; X=0, T0=255 all pixels; others T=X -> Dist0=4080 (no overflow), WinIdx=1, WinDist=0.
3. Tie: Mode 0; channels 0 and 2 both sum to 48, channels 1 and 3 larger -> WinIdx=0, WinDist=48.
4. Mode 1; X ramps 0..15; T0=5, T1=15, T2=0, T3=8 -> Dist={10,15,15,8}, WinIdx=3, WinDist=8. Toggle Mode to 0 at pixel 7 -> result unchanged.
5. Handshakes:
   - InValid gaps (every other cycle) -> same results as the gapless run.
   - OutReady low 5 cycles -> OutValid held, outputs stable, InReady=0, X activity ignored.
   - Next block starts the cycle after the handshake.
6. Rst pulsed after 7 accepted pixels, then during CMP -> all outputs 0, InReady=1, no OutValid. The following clean 16-pixel block matches scenario 1.
